mem_io_responder: RTL and testbench

Target side of the CPU's byte-wide memory bus: the block that drives `mem_din` and `io_buffer_full` back to the CPU. It serves byte reads and writes to 128 KB of RAM and the memory-mapped I/O window, and buffers UART transmit and receive bytes in FIFOs. It also keeps the cycle counter and runs the program-stop sequence. It sits beside the CPU in the top-level SoC, between the CPU bus and the UART.

---
 rtl/mem_io_pkg.sv | 21 ++
 rtl/mem_io_responder_if.sv | 11 +
 rtl/byte_fifo.sv | 47 ++++
 rtl/mem_io_responder.sv | 158 +++++++++++++++
 tb/tb_mem_io_responder.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_io_pkg.sv
// Shared constants, stop-sequence state type and debug bundle for mem_io_responder.
package mem_io_pkg;

    localparam logic [17:0] IO_UART = 18'h30000;
    localparam logic [17:0] IO_CTRL = 18'h30004;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        PUSH0 = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } stop_state_t;

    typedef struct packed {
        stop_state_t state;
        logic        tx_ovf;
        logic [7:0]  tx_count;
        logic [7:0]  rx_count;
    } mem_io_dbg_t;

endpackage

// File: rtl/mem_io_responder_if.sv
// CPU-side byte bus: the CPU (master) drives address/direction/data, the responder returns read data and TX back-pressure.
interface mem_io_responder_if;
    logic [31:0] bus_a;
    logic        bus_wr;
    logic [7:0]  bus_wdata;
    logic [7:0]  bus_rdata;
    logic        io_buffer_full;

    modport master (output bus_a, bus_wr, bus_wdata, input bus_rdata, io_buffer_full);
    modport slave  (input bus_a, bus_wr, bus_wdata, output bus_rdata, io_buffer_full);
endinterface

// File: rtl/byte_fifo.sv
// Byte FIFO with count/full/empty; a push and a pop in the same cycle are both taken, even when full.
module byte_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [7:0]             wdata,
    output logic [7:0]             rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop && !empty;
    // A pop frees the slot the simultaneous push lands in.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end
endmodule

// File: rtl/mem_io_responder.sv
// CPU bus target: RAM, UART TX/RX FIFOs, cycle counter and program-stop sequence.
// Build option: define MEM_IO_CYCLE_COUNTER_EN to include the cycle counter and its snapshot.
module mem_io_responder
    import mem_io_pkg::*;
#(
    parameter int RAM_ADDR_W = 17,
    parameter int TX_DEPTH   = 8,
    parameter int RX_DEPTH   = 8
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    mem_io_responder_if.slave    bus,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    input  logic [7:0]           rx_data,
    input  logic                 rx_valid,
    output logic                 rx_ready,
    output logic                 program_done,
    output mem_io_dbg_t          dbg
);
    // Handshake: a byte moves on tx/rx when valid, ready and rdy_in are all high at a rising
    // edge; valid never depends on ready, and data is stable while valid waits.
    localparam int TXW = $clog2(TX_DEPTH) + 1;
    localparam int RXW = $clog2(RX_DEPTH) + 1;

    logic [TXW-1:0]        tx_count;
    logic [RXW-1:0]        rx_count;
    logic                  tx_full, tx_empty, rx_full, rx_empty;
    logic [7:0]            tx_head, rx_head, tx_wdata;
    logic                  tx_push, tx_pop, rx_push, rx_pop;
    logic                  io_sel, uart_rd, tx_wr_req, ctrl_wr, fsm_push;
    logic [2:0]            io_off;
    logic [RAM_ADDR_W-1:0] ram_idx;
    logic [7:0]            ram [2**RAM_ADDR_W];
    logic [7:0]            rd_byte;
    logic [7:0]            rdata_q;
    logic                  tx_ovf;
    logic                  done_q;
    stop_state_t           state;
    logic                  unused_addr_bits;

    assign unused_addr_bits = ^bus.bus_a[31:18];

    assign io_sel  = (bus.bus_a[17:16] == IO_UART[17:16]);
    assign io_off  = bus.bus_a[2:0];
    assign ram_idx = bus.bus_a[RAM_ADDR_W-1:0];

    assign uart_rd   = rdy_in && io_sel && !bus.bus_wr && (io_off == IO_UART[2:0]);
    assign tx_wr_req = rdy_in && io_sel && bus.bus_wr && (io_off == IO_UART[2:0])
                       && (bus.bus_wdata != 8'h00) && (state == RUN);
    assign ctrl_wr   = rdy_in && io_sel && bus.bus_wr && (io_off == IO_CTRL[2:0]);
    assign fsm_push  = rdy_in && (state == PUSH0) && !tx_full;

    assign tx_pop   = rdy_in && !tx_empty && tx_ready;
    assign tx_push  = tx_wr_req || fsm_push;
    assign tx_wdata = fsm_push ? 8'h00 : bus.bus_wdata;
    assign rx_push  = rdy_in && rx_valid && !rx_full;
    assign rx_pop   = uart_rd && !rx_empty;

    byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk   (clk_in),
        .rst_n (rst_in),
        .push  (tx_push),
        .pop   (tx_pop),
        .wdata (tx_wdata),
        .rdata (tx_head),
        .count (tx_count),
        .full  (tx_full),
        .empty (tx_empty)
    );

    byte_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk   (clk_in),
        .rst_n (rst_in),
        .push  (rx_push),
        .pop   (rx_pop),
        .wdata (rx_data),
        .rdata (rx_head),
        .count (rx_count),
        .full  (rx_full),
        .empty (rx_empty)
    );

    always_ff @(posedge clk_in) begin
        if (rdy_in && !io_sel && bus.bus_wr) ram[ram_idx] <= bus.bus_wdata;
    end

`ifdef MEM_IO_CYCLE_COUNTER_EN
    logic [31:0] cycle_cnt;
    logic [31:0] snapshot;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            cycle_cnt <= '0;
            snapshot  <= '0;
        end else if (rdy_in) begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (io_sel && !bus.bus_wr && (io_off == IO_CTRL[2:0])) snapshot <= cycle_cnt;
        end
    end
`endif

    always_comb begin
        rd_byte = 8'h00;
        if (!io_sel) begin
            rd_byte = ram[ram_idx];
        end else begin
            case (io_off)
                3'd0:    rd_byte = rx_empty ? 8'h00 : rx_head;
`ifdef MEM_IO_CYCLE_COUNTER_EN
                3'd4:    rd_byte = cycle_cnt[7:0];
                3'd5:    rd_byte = snapshot[15:8];
                3'd6:    rd_byte = snapshot[23:16];
                3'd7:    rd_byte = snapshot[31:24];
`endif
                default: rd_byte = 8'h00;
            endcase
        end
    end

    // Read data is held across write cycles until the next read.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in)                    rdata_q <= 8'h00;
        else if (rdy_in && !bus.bus_wr) rdata_q <= rd_byte;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in)                              tx_ovf <= 1'b0;
        else if (tx_wr_req && tx_full && !tx_pop) tx_ovf <= 1'b1;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state  <= RUN;
            done_q <= 1'b0;
        end else if (rdy_in) begin
            case (state)
                RUN:   if (ctrl_wr) state <= PUSH0;
                PUSH0: if (!tx_full) state <= DRAIN;
                DRAIN: if (tx_empty && !tx_valid) begin
                    state  <= DONE;
                    done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.bus_rdata      = rdata_q;
    assign bus.io_buffer_full = (tx_count >= TXW'(TX_DEPTH - 2));
    assign tx_valid           = !tx_empty;
    assign tx_data            = tx_empty ? 8'h00 : tx_head;
    assign rx_ready           = !rx_full;
    assign program_done       = done_q;
    assign dbg = '{state: state, tx_ovf: tx_ovf, tx_count: 8'(tx_count), rx_count: 8'(rx_count)};
endmodule

// File: tb/tb_mem_io_responder.sv
// Randomized bench for mem_io_responder against a queue/array model of the bus target.
module tb_mem_io_responder;
    import mem_io_pkg::*;

    localparam int TX_DEPTH = 8;
    localparam int RX_DEPTH = 8;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        program_done;
    mem_io_dbg_t dbg;

    mem_io_responder_if bus ();

    mem_io_responder #(.RAM_ADDR_W(17), .TX_DEPTH(TX_DEPTH), .RX_DEPTH(RX_DEPTH)) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .rdy_in       (rdy_in),
        .bus          (bus.slave),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .program_done (program_done),
        .dbg          (dbg)
    );

    // clock / reset
    always #5 clk_in = ~clk_in;

    int checks   = 0;
    int failures = 0;
    bit check_en = 0;

    // model state
    logic [7:0] m_ram   [0:131071];
    bit         m_known [0:131071];
    logic [7:0] exp_tx_q[$];
    logic [7:0] exp_rx_q[$];
    logic [7:0] m_rdata;
    bit         m_rdata_known;
    logic [31:0] m_cnt, m_snap;
    bit m_ovf, m_stop_req, m_zero_queued, m_done;
    logic [7:0] tx_seen[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_tx_q.delete();
        exp_rx_q.delete();
        m_rdata = 8'h00; m_rdata_known = 1;
        m_cnt = 0; m_snap = 0;
        m_ovf = 0; m_stop_req = 0; m_zero_queued = 0; m_done = 0;
    endtask

    task automatic model_step();
        int txn, rxn, idx;
        bit tx_pop, rx_push, rx_pop, tx_push, io, stop_was;
        logic [7:0] tx_byte, rd;
        bit rd_known;
        logic [2:0] off;
        txn = exp_tx_q.size();
        rxn = exp_rx_q.size();
        tx_pop  = (txn > 0) && tx_ready;
        rx_push = rx_valid && (rxn < RX_DEPTH);
        rx_pop = 0; tx_push = 0; tx_byte = 8'h00;
        io  = (bus.bus_a[17:16] == 2'b11);
        off = bus.bus_a[2:0];
        idx = int'(bus.bus_a[16:0]);
        stop_was = m_stop_req;
        // stop sequence: queue one zero byte once there is room, then finish when TX is empty
        if (m_stop_req && !m_zero_queued) begin
            if (txn < TX_DEPTH) begin tx_push = 1; tx_byte = 8'h00; m_zero_queued = 1; end
        end else if (m_zero_queued && !m_done && txn == 0) begin
            m_done = 1;
        end
        if (!bus.bus_wr) begin
            rd = 8'h00; rd_known = 1;
            if (!io) begin
                rd = m_ram[idx]; rd_known = m_known[idx];
            end else begin
                case (off)
                    3'd0: if (rxn > 0) begin rd = exp_rx_q[0]; rx_pop = 1; end
`ifdef MEM_IO_CYCLE_COUNTER_EN
                    3'd4: begin rd = m_cnt[7:0]; m_snap = m_cnt; end
                    3'd5: rd = m_snap[15:8];
                    3'd6: rd = m_snap[23:16];
                    3'd7: rd = m_snap[31:24];
`endif
                    default: rd = 8'h00;
                endcase
            end
            m_rdata = rd; m_rdata_known = rd_known;
        end else if (!io) begin
            m_ram[idx] = bus.bus_wdata; m_known[idx] = 1;
        end else if (off == 3'd0 && bus.bus_wdata != 8'h00 && !stop_was) begin
            if (txn < TX_DEPTH || tx_pop) begin tx_push = 1; tx_byte = bus.bus_wdata; end
            else m_ovf = 1;
        end else if (off == 3'd4 && !stop_was) begin
            m_stop_req = 1;
        end
        if (tx_pop)  void'(exp_tx_q.pop_front());
        if (tx_push) exp_tx_q.push_back(tx_byte);
        if (rx_pop)  void'(exp_rx_q.pop_front());
        if (rx_push) exp_rx_q.push_back(rx_data);
        m_cnt = m_cnt + 32'd1;
    endtask

    always @(posedge clk_in or negedge rst_in) begin
        if (!rst_in)     model_reset();
        else if (rdy_in) model_step();
    end

    always @(posedge clk_in) begin
        if (rst_in && rdy_in && tx_valid && tx_ready) tx_seen.push_back(tx_data);
    end

    // scoreboard compare, away from the active edge
    always @(negedge clk_in) begin
        if (check_en) begin
            if (m_rdata_known) chk("bus_rdata", bus.bus_rdata, m_rdata);
            chk("tx_valid", tx_valid, exp_tx_q.size() > 0);
            chk("tx_data", tx_data, exp_tx_q.size() > 0 ? exp_tx_q[0] : 8'h00);
            chk("io_buffer_full", bus.io_buffer_full, exp_tx_q.size() >= TX_DEPTH - 2);
            chk("rx_ready", rx_ready, exp_rx_q.size() < RX_DEPTH);
            chk("program_done", program_done, m_done);
            chk("tx_ovf", dbg.tx_ovf, m_ovf);
            chk("tx_count", dbg.tx_count, exp_tx_q.size());
            chk("rx_count", dbg.rx_count, exp_rx_q.size());
        end
    end

    // driver tasks
    task automatic drive(input logic [31:0] a, input bit wr, input logic [7:0] d);
        bus.bus_a = a; bus.bus_wr = wr; bus.bus_wdata = d;
        @(posedge clk_in); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(32'h0, 1'b0, 8'h00);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_rdata"}, bus.bus_rdata, 8'h00);
        chk({tag, "_iobf"}, bus.io_buffer_full, 1'b0);
        chk({tag, "_tx_valid"}, tx_valid, 1'b0);
        chk({tag, "_tx_data"}, tx_data, 8'h00);
        chk({tag, "_rx_ready"}, rx_ready, 1'b1);
        chk({tag, "_done"}, program_done, 1'b0);
        chk({tag, "_state"}, dbg.state, RUN);
        chk({tag, "_tx_count"}, dbg.tx_count, 8'd0);
    endtask

    function automatic logic [31:0] pick_ram_addr();
        logic [31:0] base;
        base = ($urandom_range(0, 1) == 0) ? 32'h00000 : 32'h1FFE0;
        return (($urandom() & 32'hFFFC_0000) | base) + 32'($urandom_range(0, 31));
    endfunction

    logic [7:0]  snap_b [4];
    logic [31:0] snap_v;
    int          budget;

    initial begin
        rst_in = 1'b0; rdy_in = 1'b1; tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        bus.bus_a = 32'h0; bus.bus_wr = 1'b0; bus.bus_wdata = 8'h00;
        model_reset();
        repeat (3) @(posedge clk_in);
        #1;
        chk_reset_values("reset");
        rst_in = 1'b1;
        check_en = 1;

        // RAM write then read-after-write
        drive(32'h0, 1'b1, 8'h5A);
        drive(32'h10, 1'b1, 8'hA5);
        drive(32'h10, 1'b0, 8'h00);
        chk("ram_raw", bus.bus_rdata, 8'hA5);

        // zero byte to UART is not queued
        drive(32'h30000, 1'b1, 8'h00);
        chk("zero_write_tx_valid", tx_valid, 1'b0);

        // TX fill, near-full warning and overflow
        for (int i = 1; i <= 9; i++) begin
            drive(32'h30000, 1'b1, 8'h41);
            if (i == 5) chk("iobf_after_5", bus.io_buffer_full, 1'b0);
            if (i == 6) chk("iobf_after_6", bus.io_buffer_full, 1'b1);
            if (i == 8) chk("ovf_after_8", dbg.tx_ovf, 1'b0);
        end
        chk("ovf_set", dbg.tx_ovf, 1'b1);
        chk("tx_count_full", dbg.tx_count, 8'd8);
        tx_ready = 1'b1;
        idle(10);
        chk("tx_drained", tx_valid, 1'b0);

        // RX byte then two UART reads
        rx_data = 8'h37; rx_valid = 1'b1;
        idle(1);
        rx_valid = 1'b0;
        drive(32'h30000, 1'b0, 8'h00);
        chk("rx_first", bus.bus_rdata, 8'h37);
        drive(32'h30000, 1'b0, 8'h00);
        chk("rx_empty", bus.bus_rdata, 8'h00);

        // preload two RAM windows, then random traffic
        for (int i = 0; i < 32; i++) drive(32'(i), 1'b1, 8'($urandom()));
        for (int i = 0; i < 32; i++) drive(32'h1FFE0 + 32'(i), 1'b1, 8'($urandom()));
        for (int n = 0; n < 1500; n++) begin
            int op;
            rdy_in   = ($urandom_range(0, 9) != 0);
            tx_ready = $urandom_range(0, 1);
            rx_valid = ($urandom_range(0, 9) < 4);
            rx_data  = 8'($urandom());
            op = $urandom_range(0, 9);
            case (op)
                0, 1, 2: drive(pick_ram_addr(), 1'b0, 8'h00);
                3, 4:    drive(pick_ram_addr(), 1'b1, 8'($urandom()));
                5:       drive(32'h30000, 1'b0, 8'h00);
                6, 8:    drive(32'h30000, 1'b1, ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom()));
                7:       drive(32'h30004 + 32'($urandom_range(0, 3)), 1'b0, 8'h00);
                default: drive(32'h30000 + 32'($urandom_range(1, 3)), 1'b0, 8'h00);
            endcase
        end
        rdy_in = 1'b1; rx_valid = 1'b0; tx_ready = 1'b1;
        for (int i = 0; i < RX_DEPTH + 2; i++) drive(32'h30000, 1'b0, 8'h00);
        idle(12);

        // cycle counter snapshot
        idle(1000);
        for (int i = 0; i < 4; i++) begin
            drive(32'h30004 + 32'(i), 1'b0, 8'h00);
            snap_b[i] = bus.bus_rdata;
        end
        snap_v = {snap_b[3], snap_b[2], snap_b[1], snap_b[0]};
`ifdef MEM_IO_CYCLE_COUNTER_EN
        chk("snapshot_range", (snap_v >= 32'd1000) && (snap_v < 32'd100000), 1'b1);
        drive(32'h30005, 1'b0, 8'h00);
        chk("snapshot_reread", bus.bus_rdata, m_snap[15:8]);
`else
        chk("snapshot_absent", snap_v, 32'h0);
`endif

        // stop sequence with TX stream capture
        tx_ready = 1'b0;
        drive(32'h30000, 1'b1, 8'h48);
        drive(32'h30000, 1'b1, 8'h49);
        tx_seen.delete();
        tx_ready = 1'b1;
        drive(32'h30004, 1'b1, 8'h01);
        budget = 0;
        while (!program_done && budget < 50) begin
            idle(1);
            budget++;
        end
        chk("program_done_rise", program_done, 1'b1);
        chk("tx_stream_len", tx_seen.size(), 3);
        if (tx_seen.size() == 3) begin
            chk("tx_stream_0", tx_seen[0], 8'h48);
            chk("tx_stream_1", tx_seen[1], 8'h49);
            chk("tx_stream_2", tx_seen[2], 8'h00);
        end
        drive(32'h30000, 1'b1, 8'h55);
        chk("tx_ignored_after_done", tx_valid, 1'b0);
        drive(32'h20, 1'b1, 8'h3C);
        drive(32'h20, 1'b0, 8'h00);
        chk("ram_after_done", bus.bus_rdata, 8'h3C);

        // reset while draining
        rst_in = 1'b0;
        #2;
        rst_in = 1'b1;
        tx_ready = 1'b0;
        drive(32'h30000, 1'b1, 8'h77);
        drive(32'h30004, 1'b1, 8'h00);
        idle(3);
        chk("drain_state", dbg.state, DRAIN);
        chk("drain_tx_count", dbg.tx_count, 8'd2);
        rst_in = 1'b0;
        #2;
        chk_reset_values("mid_drain_reset");
        @(posedge clk_in); #1;
        check_en = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
